// File: rtl/conv_pkg.sv
// conv_pkg: shared constants for the convolution filter path
package conv_pkg;
  localparam int TAPS        = 5;
  localparam int HIST_LINES  = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int TAP_LATENCY = 2;
endpackage

// File: rtl/line_ram.sv
// line_ram: one-line buffer with a write port and a registered read port that returns the old word on a same-address write
module line_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/conv_line_tap_gen.sv
// conv_line_tap_gen: five vertically aligned pixel taps from a raster stream using four ring-rotated line RAMs
module conv_line_tap_gen
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LINE_MAX = 2048,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dv_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [DATA_W-1:0] px_in,
  output logic [DATA_W-1:0] pa,
  output logic [DATA_W-1:0] pb,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] pd,
  output logic [DATA_W-1:0] pe,
  output logic              dv_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic              taps_full
);
  logic [ADDR_W-1:0] col_q, col_d;
  logic ovf_q, ovf_d, dv_prev_q, vs_prev_q, fall, vs_rise, last, we;
  logic [1:0] wptr_q, wptr_d, wp1_q;
  logic [2:0] lc_q, lc_d;
  logic [DATA_W-1:0] px1_q;
  logic [HIST_LINES-1:0] mask1_q, mask1_d;
  logic dv1_q, hs1_q, vs1_q, full1_q, dv2_q, hs2_q, vs2_q, full2_q;
  logic [DATA_W-1:0] rd [HIST_LINES];
  logic [DATA_W-1:0] tap_q [TAPS];
  logic [DATA_W-1:0] tap_d [TAPS];
  always_comb begin
    fall = dv_prev_q & ~dv_in;
    vs_rise = vs_in & ~vs_prev_q;
    last = col_q == ADDR_W'(LINE_MAX - 1);
    we = dv_in & ~ovf_q & ~rst;
    col_d = dv_in ? (last ? col_q : col_q + 1'b1) : '0;
    ovf_d = dv_in & (ovf_q | last);
    wptr_d = wptr_q + 2'(fall);
    lc_d = vs_rise ? '0 : (fall && lc_q != 3'(HIST_LINES)) ? lc_q + 1'b1 : lc_q;
    for (int k = 0; k < HIST_LINES; k++) mask1_d[k] = dv_in & ~ovf_q & (lc_q > 3'(k));
    tap_d[0] = dv1_q ? px1_q : '0;
    // line-k lives k slots behind the slot captured with the read
    for (int k = 1; k < TAPS; k++) tap_d[k] = mask1_q[k-1] ? rd[wp1_q - 2'(k)] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      ovf_q <= 1'b0;
      dv_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      wptr_q <= '0;
      lc_q <= '0;
      px1_q <= '0;
      mask1_q <= '0;
      wp1_q <= '0;
      {dv1_q, hs1_q, vs1_q, full1_q} <= '0;
      {dv2_q, hs2_q, vs2_q, full2_q} <= '0;
      tap_q <= '{default: '0};
    end else begin
      col_q <= col_d;
      ovf_q <= ovf_d;
      dv_prev_q <= dv_in;
      vs_prev_q <= vs_in;
      wptr_q <= wptr_d;
      lc_q <= lc_d;
      px1_q <= px_in;
      mask1_q <= mask1_d;
      wp1_q <= wptr_q;
      {dv1_q, hs1_q, vs1_q, full1_q} <= {dv_in, hs_in, vs_in, lc_q == 3'(HIST_LINES)};
      {dv2_q, hs2_q, vs2_q, full2_q} <= {dv1_q, hs1_q, vs1_q, dv1_q & full1_q};
      tap_q <= tap_d;
    end
  end
  for (genvar i = 0; i < HIST_LINES; i++) begin : g_ram
    line_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk     (clk),
      .we      (we && wptr_q == 2'(i)),
      .wr_addr (col_q),
      .wr_data (px_in),
      .rd_addr (col_q),
      .rd_data (rd[i])
    );
  end
  assign {pa, pb, pc, pd, pe} = {tap_q[0], tap_q[1], tap_q[2], tap_q[3], tap_q[4]};
  assign {dv_out, hs_out, vs_out, taps_full} = {dv2_q, hs2_q, vs2_q, full2_q};
endmodule

// File: tb/tb_conv_line_tap_gen.sv
// tb_conv_line_tap_gen: scoreboard plus spot-vector bench for the line tap generator
module tb_conv_line_tap_gen;
  localparam int LM = 16;
  typedef struct { logic dv, hs, vs, full; logic [39:0] tp; int sec, line, col; } exp_t;
  typedef struct { int line, col; logic [39:0] tp; logic full; } vec_t;
  logic clk = 0, rst = 1, dv_in = 0, hs_in = 0, vs_in = 0;
  logic [7:0] px_in = 0;
  logic [7:0] pa, pb, pc, pd, pe;
  logic dv_out, hs_out, vs_out, taps_full;
  exp_t q[$];
  vec_t vt[7];
  int pass_n = 0, tot = 0, cyc = 0, t_dv = -1, sec = 0;
  int col = 0, lc = 0, tag = 0;
  bit lat_seen = 0;
  logic dv_prev = 0, vs_prev = 0;
  always #5 clk = ~clk;
  conv_line_tap_gen #(.DATA_W(8), .LINE_MAX(LM), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .dv_in(dv_in), .hs_in(hs_in), .vs_in(vs_in), .px_in(px_in),
    .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe),
    .dv_out(dv_out), .hs_out(hs_out), .vs_out(vs_out), .taps_full(taps_full)
  );
  function automatic logic [7:0] pix(int t, int c);
    return 8'(t * 16 + c);
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic check_out(input exp_t e);
    chk($sformatf("sb s%0d l%0d c%0d", e.sec, e.line, e.col),
        64'({dv_out, hs_out, vs_out, taps_full, pa, pb, pc, pd, pe}),
        64'({e.dv, e.hs, e.vs, e.full, e.tp}));
    if (e.sec == 1)
      foreach (vt[i])
        if (vt[i].line == e.line && vt[i].col == e.col)
          chk($sformatf("vec l%0d c%0d", e.line, e.col),
              64'({taps_full, pa, pb, pc, pd, pe}), 64'({vt[i].full, vt[i].tp}));
    if (!lat_seen && dv_out) begin
      lat_seen = 1;
      chk("latency", 64'(cyc - t_dv), 64'd2);
    end
  endtask
  task automatic step(input logic dv, input logic hs, input logic vs, input logic [7:0] px);
    exp_t e;
    logic [7:0] ex [5];
    @(posedge clk); #1;
    cyc++;
    if (q.size() == 2) check_out(q.pop_front());
    dv_in = dv; hs_in = hs; vs_in = vs; px_in = px;
    if (dv && t_dv < 0) t_dv = cyc;
    ex[0] = dv ? px : 8'h00;
    for (int k = 1; k < 5; k++) ex[k] = (dv && lc >= k && col < LM) ? pix(tag - k, col) : 8'h00;
    e.sec = sec; e.line = dv ? tag : -1; e.col = col;
    e.dv = dv; e.hs = hs; e.vs = vs; e.full = dv && lc == 4;
    e.tp = {ex[0], ex[1], ex[2], ex[3], ex[4]};
    q.push_back(e);
    col = dv ? col + 1 : 0;
    if (dv_prev && !dv) begin tag++; lc = (lc < 4) ? lc + 1 : 4; end
    if (vs && !vs_prev) lc = 0;
    dv_prev = dv; vs_prev = vs;
  endtask
  task automatic line(input int n);
    for (int c = 0; c < n; c++) step(1, 0, 0, pix(tag, c));
    for (int i = 0; i < 4; i++) step(0, i == 1, 0, 8'h00);
  endtask
  task automatic vsync();
    step(0, 0, 1, 8'h00);
    step(0, 0, 0, 8'h00);
  endtask
  initial begin
    vt[0] = '{4, 3, 40'h43_33_23_13_03, 1'b1};
    vt[1] = '{0, 0, 40'h00_00_00_00_00, 1'b0};
    vt[2] = '{0, 5, 40'h05_00_00_00_00, 1'b0};
    vt[3] = '{2, 1, 40'h21_11_01_00_00, 1'b0};
    vt[4] = '{2, 6, 40'h26_16_06_00_00, 1'b0};
    vt[5] = '{3, 7, 40'h37_27_17_07_00, 1'b0};
    vt[6] = '{5, 0, 40'h50_40_30_20_10, 1'b1};
    repeat (5) @(posedge clk);
    #1;
    chk("reset", 64'({dv_out, hs_out, vs_out, taps_full, pa, pb, pc, pd, pe}), 64'd0);
    rst = 0;
    sec = 1;
    vsync();
    repeat (6) line(8);
    if (!lat_seen) chk("latency timeout", 64'd0, 64'd1);
    sec = 2;
    vsync();
    repeat (9) line(8);
    sec = 3;
    vsync();
    repeat (3) line(8);
    for (int c = 0; c < 4; c++) step(1, 0, 0, pix(tag, c));
    @(posedge clk); #1;
    rst = 1; dv_in = 1; px_in = pix(tag, 4);
    @(posedge clk); #1;
    chk("rst mid", 64'({dv_out, hs_out, vs_out, taps_full, pa, pb, pc, pd, pe}), 64'd0);
    for (int c = 5; c < 8; c++) begin px_in = pix(tag, c); @(posedge clk); #1; end
    dv_in = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst hold", 64'({dv_out, hs_out, vs_out, taps_full, pa, pb, pc, pd, pe}), 64'd0);
    rst = 0;
    q.delete();
    col = 0; lc = 0; dv_prev = 0; vs_prev = 0; tag++;
    vsync();
    line(8);
    line(8);
    sec = 4;
    vsync();
    repeat (3) line(20);
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    $display("%0d/%0d checks passed", pass_n, tot);
    $finish;
  end
endmodule
